// File: rtl/tx_spi_fifo.sv
// Buffers words from an SPI slave into a first-word-fall-through FIFO for a packet framer.
// Latency: a strobe rising edge writes the same cycle; the word is visible on fr_* the next cycle.
// Backpressure: spi_data_request throttles the SPI master; a push into a full FIFO is dropped (overrun).
// Optional build macro TX_JABBER_EN adds a per-packet cycle limit that sets jabber and flushes.
module tx_spi_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int JABBER_MAX = 1048575
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              spi_data,
  input  logic                     spi_data_strobe,
  output logic                     spi_data_request,
  input  logic                     go,
  input  logic                     abort,
  output logic [DATA_W-1:0]        fr_data,
  output logic                     fr_eop,
  output logic                     fr_valid,
  input  logic                     fr_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic                     underrun,
  output logic                     jabber
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] REQ_LVL  = LVL_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               strobe_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               req_q, req_d;
  logic               overrun_q, overrun_d;
  logic               underrun_q, underrun_d;
  logic [DATA_W:0]    mem_q [DEPTH];

  logic strobe_edge, data_edge, full, pop, push, kill, go_acc, jab_hit;

  // Bits above the payload width are don't-care for narrow builds.
  logic unused_spi_bits;
  assign unused_spi_bits = &{1'b0, spi_data[13:0]};

  assign strobe_edge = spi_data_strobe & ~strobe_q;
  assign data_edge   = strobe_edge & spi_data[14];
  assign fr_valid    = (level_q != '0);
  assign full        = (level_q == FULL_LVL);
  assign pop         = fr_valid & fr_ready;
  // Abort (or a jabber timeout) wins over every other input this cycle.
  assign kill        = abort | jab_hit;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push        = data_edge & (~full | pop) & ~kill;
  assign go_acc      = (state_q == S_IDLE) & go & ~kill;

  assign fr_data          = mem_q[rd_ptr_q][DATA_W-1:0];
  assign fr_eop           = mem_q[rd_ptr_q][DATA_W];
  assign level            = level_q;
  assign spi_data_request = req_q;
  assign overrun          = overrun_q;
  assign underrun         = underrun_q;

`ifdef TX_JABBER_EN
  localparam int CNT_W = $clog2(JABBER_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(JABBER_MAX - 1);

  logic [CNT_W-1:0] jcnt_q, jcnt_d;
  logic             jabber_q, jabber_d;
  logic             busy;

  assign busy    = (state_q != S_IDLE);
  // The counter becomes JABBER_MAX on this edge: time is up for the packet.
  assign jab_hit = busy & (jcnt_q == CNT_LAST);
  assign jabber  = jabber_q;

  // Packet-duration counter and its sticky flag.
  always_comb begin
    jcnt_d   = jcnt_q;
    jabber_d = jabber_q;
    if (go_acc) begin
      jcnt_d   = '0;
      jabber_d = 1'b0;
    end else if (jab_hit) begin
      jcnt_d   = '0;
      jabber_d = 1'b1;
    end else if (busy) begin
      jcnt_d   = jcnt_q + CNT_W'(1);
    end
  end

  // Jabber registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jcnt_q   <= '0;
      jabber_q <= 1'b0;
    end else begin
      jcnt_q   <= jcnt_d;
      jabber_q <= jabber_d;
    end
  end
`else
  assign jab_hit = 1'b0;
  assign jabber  = 1'b0;
`endif

  // Next-state: FIFO pointers/level, packet FSM, request and sticky flags.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    if (data_edge && full && !pop && !kill) overrun_d = 1'b1;
    if (fr_ready && !fr_valid && state_q == S_FILL) underrun_d = 1'b1;

    case (state_q)
      S_IDLE:  if (go_acc) begin
                 state_d    = S_FILL;
                 overrun_d  = 1'b0;
                 underrun_d = 1'b0;
               end
      S_FILL:  if (strobe_edge && spi_data[15]) state_d = S_DRAIN;
      S_DRAIN: if (level_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    req_d = (state_d == S_FILL) && (level_d < REQ_LVL);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      strobe_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      req_q      <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      strobe_q   <= spi_data_strobe;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      req_q      <= req_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage array; contents are qualified by level, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {spi_data[15], spi_data[DATA_W-1:0]};
  end

endmodule

// File: tb/tb_tx_spi_fifo.sv
// Bench for tx_spi_fifo: directed packets, a scoreboard of expected FIFO pops and
// direct checks of level, request and sticky flags; the jabber case follows TX_JABBER_EN.
module tb_tx_spi_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] spi_data = '0;
  logic        spi_data_strobe = 1'b0;
  logic        spi_data_request;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  fr_data;
  logic        fr_eop;
  logic        fr_valid;
  logic        fr_ready = 1'b0;
  logic [2:0]  level;
  logic        overrun, underrun, jabber;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  tx_spi_fifo #(.DATA_W(8), .DEPTH(4), .JABBER_MAX(100)) dut (
    .clk(clk), .reset(reset), .spi_data(spi_data), .spi_data_strobe(spi_data_strobe),
    .spi_data_request(spi_data_request), .go(go), .abort(abort),
    .fr_data(fr_data), .fr_eop(fr_eop), .fr_valid(fr_valid), .fr_ready(fr_ready),
    .level(level), .overrun(overrun), .underrun(underrun), .jabber(jabber)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    spi_data = w;
    spi_data_strobe = 1'b1;
    tick();
    spi_data_strobe = 1'b0;
    tick();
  endtask

  task automatic start_pkt;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Monitor: every pop the DUT will perform on the next edge must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && fr_valid && fr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected actual=%0h expected=none", {fr_eop, fr_data});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({fr_eop, fr_data} !== mon_exp) begin
          failures++;
          $display("FAIL pop_data actual=%0h expected=%0h", {fr_eop, fr_data}, mon_exp);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", fr_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_req", spi_data_request, 0);
    chk("rst_flags", {overrun, underrun, jabber}, 0);
    reset = 1'b0;
    tick();

    // Three-word packet streamed straight through
    fr_ready = 1'b1;
    start_pkt();
    chk("p1_req_fill", spi_data_request, 1);
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h022);
    exp_q.push_back(9'h133);
    send_word(16'h4011);
    send_word(16'h4022);
    send_word(16'hC033);
    chk("p1_req_after_eop", spi_data_request, 0);
    repeat (3) tick();
    chk("p1_level", level, 0);
    chk("p1_valid", fr_valid, 0);
    chk("p1_underrun", underrun, 1);
    start_pkt();
    chk("go_clears_underrun", underrun, 0);
    chk("p2_req_fill", spi_data_request, 1);

    // Fill to full, simultaneous push+pop, then overrun
    fr_ready = 1'b0;
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h004);
    exp_q.push_back(9'h005);
    send_word(16'h4001);
    chk("l1_level", level, 1);
    chk("l1_req", spi_data_request, 1);
    send_word(16'h4002);
    chk("l2_req", spi_data_request, 1);
    send_word(16'h4003);
    chk("l3_level", level, 3);
    chk("l3_req", spi_data_request, 0);
    send_word(16'h4004);
    chk("l4_level", level, 4);
    spi_data = 16'h4005;
    spi_data_strobe = 1'b1;
    fr_ready = 1'b1;
    tick();
    spi_data_strobe = 1'b0;
    fr_ready = 1'b0;
    chk("pushpop_overrun", overrun, 0);
    chk("pushpop_level", level, 4);
    tick();
    send_word(16'h4006);
    chk("ovr_flag", overrun, 1);
    chk("ovr_level", level, 4);
    chk("ovr_head", fr_data, 8'h02);
    fr_ready = 1'b1;
    repeat (6) tick();
    chk("drain_level", level, 0);
    fr_ready = 1'b0;
    send_word(16'h8000);
    chk("eop_nodata_level", level, 0);
    tick();
    chk("eop_nodata_req", spi_data_request, 0);

    // Abort with two entries queued plus a same-cycle strobe and go
    start_pkt();
    fr_ready = 1'b1;
    tick();
    fr_ready = 1'b0;
    chk("ab_underrun_set", underrun, 1);
    send_word(16'h4041);
    send_word(16'h4042);
    chk("ab_level_before", level, 2);
    abort = 1'b1;
    go = 1'b1;
    spi_data = 16'h4043;
    spi_data_strobe = 1'b1;
    tick();
    abort = 1'b0;
    go = 1'b0;
    spi_data_strobe = 1'b0;
    chk("ab_valid", fr_valid, 0);
    chk("ab_level", level, 0);
    chk("ab_req", spi_data_request, 0);
    chk("ab_flag_kept", underrun, 1);
    tick();
    chk("ab_idle_req", spi_data_request, 0);

    // Reset mid-packet flushes; a strobe held across reset counts as a new edge
    start_pkt();
    send_word(16'h4051);
    chk("rs_level_before", level, 1);
    spi_data = 16'h4052;
    spi_data_strobe = 1'b1;
    reset = 1'b1;
    #2;
    chk("rs_level", level, 0);
    chk("rs_valid", fr_valid, 0);
    chk("rs_req", spi_data_request, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("rs_edge_level", level, 1);
    chk("rs_edge_head", fr_data, 8'h52);
    spi_data_strobe = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rs_flush", level, 0);

`ifdef TX_JABBER_EN
    start_pkt();
    send_word(16'h4077);
    repeat (97) tick();
    chk("jab_before", jabber, 0);
    chk("jab_level_before", level, 1);
    tick();
    chk("jab_set", jabber, 1);
    chk("jab_flush", level, 0);
    chk("jab_req", spi_data_request, 0);
    start_pkt();
    chk("jab_go_clear", jabber, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    start_pkt();
    repeat (120) tick();
    chk("jab_tied", jabber, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_spi_fifo.md
TX_SPI_FIFO -- requirements
Module: tx_spi_fifo

Interface
REQ-001 Parameter DATA_W, 8, payload bits per SPI word; legal range 1..14.
REQ-002 Parameter DEPTH, 4, FIFO entries; power of two, minimum 2.
REQ-003 Parameter JABBER_MAX, 1048575, maximum clk cycles per packet before jabber.
REQ-004 clk  input  1  clock; all logic is on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 spi_data  input  16  bit15 = EOP, bit14 = DATA valid, [DATA_W-1:0] = payload.
REQ-007 spi_data_strobe  input  1  word-present level from the SPI slave; only its rising edge is significant.
REQ-008 spi_data_request  output  1  asks the SPI master for further words.
REQ-009 go  input  1  starts a packet.
REQ-010 abort  input  1  flushes and returns to IDLE.
REQ-011 fr_data  output  DATA_W  FIFO head payload.
REQ-012 fr_eop  output  1  FIFO head is the last byte of the packet.
REQ-013 fr_valid  output  1  FIFO is not empty.
REQ-014 fr_ready  input  1  framer consumes the head this cycle.
REQ-015 level  output  log2(DEPTH)+1  current entry count.
REQ-016 overrun, underrun, jabber  output  1 each  sticky error flags.

Function
REQ-017 Strobe edge: rising edge detected against a registered copy of the strobe; the push occurs on the cycle the edge is seen, with no further latency.
REQ-018 Push: edge with bit14=1 writes {bit15, payload} at the tail.
  - If the FIFO is full and no pop occurs the same cycle: the word is dropped and overrun is set.
  - Simultaneous push and pop while full: push accepted, level unchanged.
REQ-019 Edge with bit14=0: nothing is written; bit15 is still honoured as end of packet.
REQ-020 The FIFO is first-word-fall-through.
  - fr_data and fr_eop are valid whenever fr_valid=1.
  - A pop happens when fr_valid and fr_ready are both high.
  - fr_ready while empty does not pop.
REQ-021 State machine IDLE/FILL/DRAIN:
  - IDLE: go -> FILL; go clears all sticky flags.
  - FILL: any edge with bit15=1 -> DRAIN.
  - DRAIN: FIFO empty -> IDLE.
  - go is ignored outside IDLE.
REQ-022 spi_data_request is a registered output: 1 in FILL while level < DEPTH-1 after this cycle's push/pop; otherwise 0.
REQ-023 underrun is set when fr_ready=1, fr_valid=0 and state=FILL.
REQ-024 abort, in any state, has priority over all other inputs:
  - next cycle: FIFO empty, state IDLE, request 0;
  - a push or go in the same cycle is discarded;
  - sticky flags are retained.
REQ-025 Wrap-around: read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; level is derived by counter, never by pointer difference alone.

Reset
REQ-026 On reset asserted, asynchronously:
  - state IDLE;
  - pointers and level 0;
  - spi_data_request, overrun, underrun and jabber 0;
  - registered strobe copy 0;
  - fr_valid 0.
REQ-027 Reset during FILL or DRAIN discards all FIFO contents; the first strobe edge after deassertion is treated as new.

Configuration
REQ-028 Macro TX_JABBER_EN.
  - Defined: a counter, 0 on entry to FILL, increments every cycle in FILL/DRAIN. When it reaches JABBER_MAX, jabber is set and the block behaves as for abort.
  - Undefined: no counter is built and jabber is tied to 0.

Verification
REQ-029 go; three words 0x4011, 0x4022, 0xC033 with fr_ready=1 -> fr_data 0x11, 0x22, 0x33; fr_eop only on 0x33; state returns to IDLE; request drops after the 0xC033 edge.
REQ-030 DEPTH=4, fr_ready=0, five data edges -> level=4, request=0 once level reaches 3, overrun=1, head still holds the first word.
REQ-031 Full FIFO with a push and fr_ready=1 in the same cycle -> no overrun, level stays 4, order preserved.
REQ-032 In FILL, empty FIFO, fr_ready=1 -> underrun=1; next go -> underrun=0.
REQ-033 abort with 2 entries queued and a simultaneous strobe edge -> next cycle fr_valid=0, level=0, IDLE. TX_JABBER_EN with JABBER_MAX=100 and no EOP -> jabber=1 at cycle 100, FIFO flushed.
